fetch_stage: RTL and testbench

- Fetch-stage control for the 5-stage RV32I pipeline.
- Owns the PC_F register and next-PC selection.
- Drives PC_F into instruction memory and captures the returned Instr_F into the IF/ID pipeline register.
- Tracks fetch faults (misaligned PC or PC outside the instruction window) and halts fetch once a faulting instruction commits out of D.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Fetch-stage control for a 5-stage RV32I pipeline. Owns the PC_F register
//   and next-PC selection, presents PC_F to instruction memory, and captures
//   the returned instruction into the IF/ID register. Fetches from a
//   misaligned PC, or from a PC outside the 4 KiB instruction window, are
//   tagged as faulting. When a faulting entry leaves D without being flushed
//   or redirected, fetch halts permanently until reset.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   Stall_F      : hold PC_F
//   Stall_D      : hold the IF/ID register
//   Flush_D      : replace IF/ID contents with a bubble
//   PCSrc_E      : taken branch/jump resolved in EX
//   PCTarget_E   : redirect target from EX
//   Instr_F      : instruction word returned for the current PC_F
//   PC_F         : current fetch address
//   Instr_D, PC_D, PCPlus4_D, Valid_D, Fault_D : IF/ID register contents
//   FetchFault   : sticky flag, fetch halted on a committed fault
//   FaultPC      : PC of the committed faulting entry
//
// Control semantics
//   The stall and flush inputs are level-sensitive qualifiers sampled on each
//   rising edge. A redirect overrides both a PC stall and a D stall, a flush
//   overrides a D stall, and nothing leaves the FAULT state except reset.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [19:0] IMEM_BASE_HI = 20'hBFC00,
   parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall_F,
   input  logic        Stall_D,
   input  logic        Flush_D,
   input  logic        PCSrc_E,
   input  logic [31:0] PCTarget_E,
   input  logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PCPlus4_D,
   output logic        Valid_D,
   output logic        Fault_D,
   output logic        FetchFault,
   output logic [31:0] FaultPC
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state;
   logic        fault_f;
   logic        commit_fault;
   logic [31:0] pc_plus4;

   assign pc_plus4 = PC_F + 32'd4;   // wraps naturally at 32 bits

   assign fault_f = (PC_F[1:0] != 2'b00) | (PC_F[31:12] != IMEM_BASE_HI);

   // The D entry really leaves D this edge: not held, not squashed by a
   // flush, and not on the wrong path of a redirect.
   assign commit_fault = Valid_D & Fault_D & ~Stall_D & ~Flush_D & ~PCSrc_E;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         PC_F       <= RESET_VECTOR;
         Instr_D    <= NOP_INSTR;
         PC_D       <= 32'd0;
         PCPlus4_D  <= 32'd0;
         Valid_D    <= 1'b0;
         Fault_D    <= 1'b0;
         FetchFault <= 1'b0;
         FaultPC    <= 32'd0;
      end else begin
         case (state)
            BOOT: begin
               // PC_F keeps the reset vector for one slot; D gets a bubble.
               state     <= RUN;
               Instr_D   <= NOP_INSTR;
               PC_D      <= 32'd0;
               PCPlus4_D <= 32'd0;
               Valid_D   <= 1'b0;
               Fault_D   <= 1'b0;
            end

            RUN: begin
               if (commit_fault) begin
                  // Halt: PC_F freezes on this very edge, D drains to a bubble.
                  state      <= FAULT;
                  FetchFault <= 1'b1;
                  FaultPC    <= PC_D;
                  Instr_D    <= NOP_INSTR;
                  PC_D       <= 32'd0;
                  PCPlus4_D  <= 32'd0;
                  Valid_D    <= 1'b0;
                  Fault_D    <= 1'b0;
               end else begin
                  if (PCSrc_E) begin
                     PC_F <= PCTarget_E;
                  end else if (!Stall_F) begin
                     PC_F <= pc_plus4;
                  end

                  if (Flush_D || PCSrc_E) begin
                     Instr_D   <= NOP_INSTR;
                     PC_D      <= 32'd0;
                     PCPlus4_D <= 32'd0;
                     Valid_D   <= 1'b0;
                     Fault_D   <= 1'b0;
                  end else if (!Stall_D) begin
                     // A faulting fetch never exposes the memory word to decode.
                     Instr_D   <= fault_f ? NOP_INSTR : Instr_F;
                     PC_D      <= PC_F;
                     PCPlus4_D <= pc_plus4;
                     Valid_D   <= 1'b1;
                     Fault_D   <= fault_f;
                  end
               end
            end

            FAULT: begin
               FetchFault <= 1'b1;
               Instr_D    <= NOP_INSTR;
               PC_D       <= 32'd0;
               PCPlus4_D  <= 32'd0;
               Valid_D    <= 1'b0;
               Fault_D    <= 1'b0;
            end

            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Bench for fetch_stage: directed scenarios with literal expectations,
//   then randomized control traffic, all checked every cycle against a
//   behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] NOP = 32'h00000013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        stall_f, stall_d, flush_d, pcsrc_e;
   logic [31:0] pc_target_e;
   logic [31:0] instr_f;
   logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fault_pc;
   logic        valid_d, fault_d, fetch_fault;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Instruction memory stand-in: each word is a fixed function of its address.
   function automatic logic [31:0] imem(input logic [31:0] a);
      return a ^ 32'h13579BDF;
   endfunction

   assign instr_f = imem(pc_f);

   fetch_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Stall_F    (stall_f),
      .Stall_D    (stall_d),
      .Flush_D    (flush_d),
      .PCSrc_E    (pcsrc_e),
      .PCTarget_E (pc_target_e),
      .Instr_F    (instr_f),
      .PC_F       (pc_f),
      .Instr_D    (instr_d),
      .PC_D       (pc_d),
      .PCPlus4_D  (pc_plus4_d),
      .Valid_D    (valid_d),
      .Fault_D    (fault_d),
      .FetchFault (fetch_fault),
      .FaultPC    (fault_pc)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr_d;
      logic [31:0] pc_d;
      logic [31:0] pc4_d;
      logic [31:0] fpc;
      logic        valid;
      logic        fault;
      logic        halted;
      logic        booting;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.pc      = RV;
      r.instr_d = NOP;
      r.pc_d    = 32'd0;
      r.pc4_d   = 32'd0;
      r.fpc     = 32'd0;
      r.valid   = 1'b0;
      r.fault   = 1'b0;
      r.halted  = 1'b0;
      r.booting = 1'b1;
      return r;
   endfunction

   function automatic model_t bubble(input model_t x);
      model_t r = x;
      r.instr_d = NOP;
      r.pc_d    = 32'd0;
      r.pc4_d   = 32'd0;
      r.valid   = 1'b0;
      r.fault   = 1'b0;
      return r;
   endfunction

   // Outside the window [BFC00000, BFC00FFF] or not word aligned.
   function automatic logic bad_pc(input logic [31:0] a);
      return (a % 4 != 0) || (a < 32'hBFC00000) || (a > 32'hBFC00FFF);
   endfunction

   function automatic model_t model_next(input model_t c, input logic sf, input logic sd,
                                         input logic fl, input logic br,
                                         input logic [31:0] tgt);
      model_t n = c;
      if (c.booting) begin
         n = bubble(c);
         n.booting = 1'b0;
      end else if (c.halted) begin
         n = bubble(c);
      end else if (c.valid && c.fault && !sd && !fl && !br) begin
         n = bubble(c);
         n.halted = 1'b1;
         n.fpc    = c.pc_d;
      end else begin
         if (fl || br) begin
            n = bubble(c);
         end else if (!sd) begin
            n.instr_d = bad_pc(c.pc) ? NOP : imem(c.pc);
            n.pc_d    = c.pc;
            n.pc4_d   = c.pc + 32'd4;
            n.valid   = 1'b1;
            n.fault   = bad_pc(c.pc);
         end
         if (br)       n.pc = tgt;
         else if (!sf) n.pc = c.pc + 32'd4;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m, stall_f, stall_d, flush_d, pcsrc_e, pc_target_e);
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_f",        pc_f,                 m.pc);
         chk("instr_d",     instr_d,              m.instr_d);
         chk("pc_d",        pc_d,                 m.pc_d);
         chk("pc_plus4_d",  pc_plus4_d,           m.pc4_d);
         chk("valid_d",     {31'd0, valid_d},     {31'd0, m.valid});
         chk("fault_d",     {31'd0, fault_d},     {31'd0, m.fault});
         chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m.halted});
         chk("fault_pc",    fault_pc,             m.fpc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_d     = 1'b0;
      pcsrc_e     = 1'b0;
      pc_target_e = 32'd0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      pcsrc_e     = 1'b1;
      pc_target_e = tgt;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pc_f",    pc_f,             RV);
      chk("rst_instr_d", instr_d,          NOP);
      chk("rst_valid",   {31'd0, valid_d}, 32'd0);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Boot and free run.
      cyc();
      chk("boot_pc_f",  pc_f,             32'hBFC00000);
      chk("boot_valid", {31'd0, valid_d}, 32'd0);
      cyc();
      chk("run1_pc_f",   pc_f,             32'hBFC00004);
      chk("run1_valid",  {31'd0, valid_d}, 32'd1);
      chk("run1_pc_d",   pc_d,             32'hBFC00000);
      chk("run1_pc4_d",  pc_plus4_d,       32'hBFC00004);
      chk("run1_instr",  instr_d,          32'hAC979BDF);
      cyc();
      chk("run2_pc_f",   pc_f,             32'hBFC00008);

      // Redirect overrides a PC stall.
      redirect(32'hBFC00100);
      stall_f = 1'b1;
      cyc();
      chk("br_pc_f",    pc_f,             32'hBFC00100);
      chk("br_valid",   {31'd0, valid_d}, 32'd0);
      chk("br_instr",   instr_d,          NOP);
      idle();
      cyc();
      chk("br_pc_d",    pc_d,             32'hBFC00100);

      // Full stall for 3 cycles at BFC00010.
      redirect(32'hBFC0000C);
      cyc();
      idle();
      cyc();
      stall_f = 1'b1;
      stall_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_pc_f",  pc_f,    32'hBFC00010);
         chk("stall_pc_d",  pc_d,    32'hBFC0000C);
         chk("stall_instr", instr_d, 32'hAC979BD3);
      end
      idle();
      cyc();
      chk("resume_pc_f", pc_f, 32'hBFC00014);
      chk("resume_pc_d", pc_d, 32'hBFC00010);

      // Misaligned fetch removed by a flush never halts fetch.
      redirect(32'hBFC00002);
      cyc();
      idle();
      cyc();
      chk("mis_fault_d", {31'd0, fault_d}, 32'd1);
      chk("mis_instr",   instr_d,          NOP);
      flush_d = 1'b1;
      cyc();
      chk("flush_fault_d", {31'd0, fault_d},     32'd0);
      chk("flush_ff",      {31'd0, fetch_fault}, 32'd0);
      flush_d = 1'b0;
      redirect(32'hBFC00200);
      cyc();
      idle();
      chk("escape_pc_f", pc_f,                 32'hBFC00200);
      chk("escape_ff",   {31'd0, fetch_fault}, 32'd0);

      // Run off the end of the window and commit the fault.
      redirect(32'hBFC00FFC);
      cyc();
      idle();
      cyc();
      cyc();
      chk("edge_pc_f",   pc_f,             32'hBFC01004);
      chk("edge_fault",  {31'd0, fault_d}, 32'd1);
      chk("edge_pc_d",   pc_d,             32'hBFC01000);
      cyc();
      chk("halt_ff",     {31'd0, fetch_fault}, 32'd1);
      chk("halt_fpc",    fault_pc,             32'hBFC01000);
      chk("halt_pc_f",   pc_f,                 32'hBFC01004);
      redirect(32'hBFC00100);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("halt_hold_pc_f",  pc_f,             32'hBFC01004);
         chk("halt_hold_valid", {31'd0, valid_d}, 32'd0);
      end

      // Asynchronous reset in the middle of a cycle while halted.
      @(posedge clk);
      #3 rst_n = 1'b0;
      idle();
      #1;
      chk("arst_pc_f", pc_f,                 RV);
      chk("arst_ff",   {31'd0, fetch_fault}, 32'd0);
      chk("arst_fpc",  fault_pc,             32'd0);
      chk("arst_valid",{31'd0, valid_d},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("reboot_pc_f", pc_f, 32'hBFC00000);
      cyc();
      chk("rerun_pc_f",  pc_f, 32'hBFC00004);
      chk("rerun_pc_d",  pc_d, 32'hBFC00000);

      // Randomized traffic, with periodic resets to recover from halts.
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            cyc();
            stall_f = ($urandom_range(0, 5) == 0);
            stall_d = stall_f | ($urandom_range(0, 9) == 0);
            flush_d = ($urandom_range(0, 9) == 0);
            pcsrc_e = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0)
               pc_target_e = $urandom();
            else if ($urandom_range(0, 15) == 0)
               pc_target_e = 32'hBFC00FF0 + 32'($urandom_range(0, 3) * 4);
            else
               pc_target_e = RV + 32'($urandom_range(0, 959) * 4);
         end
      end

      idle();
      cyc();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
